// File: rtl/util_mw_rst_sequencer.sv
// util_mw_rst_sequencer
// Staged reset release for an IP clock domain. It waits for the clock
// generator to lock and stay locked for a stability window. It then releases
// the reset outputs one at a time, in index order, and finally raises ready.
//
// Parameters:
//   NUM_STAGES         number of sequenced reset outputs (1..8)
//   LOCK_STABLE_CYCLES synchronized-lock cycles required before release (>=1)
//   STAGE_DELAY        cycles between successive stage releases (>=1)
//   TIMEOUT_CYCLES     lock watchdog limit (watchdog build only)
//
// Ports:
//   clk            sole clock
//   reset          synchronous, active-high reset
//   locked         clock generator lock, asynchronous to clk
//   soft_rst_req   single-cycle software re-sequence request
//   rst_out        active-high resets, bit 0 released first
//   ready          high once every stage is released
//   lock_lost_cnt  saturating count of lock losses in RELEASE/RUN
//   lock_timeout   sticky lock watchdog flag
//   state_dbg      current FSM state encoding
//
// Build option: define UTIL_MW_RST_SEQ_LOCK_TIMEOUT_EN to enable the lock
// watchdog. Without it, lock_timeout is tied low.

module util_mw_rst_sequencer #(
  parameter int unsigned NUM_STAGES         = 3,
  parameter int unsigned LOCK_STABLE_CYCLES = 16,
  parameter int unsigned STAGE_DELAY        = 4,
  parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  locked,
  input  logic                  soft_rst_req,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  ready,
  output logic [7:0]            lock_lost_cnt,
  output logic                  lock_timeout,
  output logic [2:0]            state_dbg
);

  localparam int unsigned CNT_LIM = (LOCK_STABLE_CYCLES > STAGE_DELAY) ?
                                    LOCK_STABLE_CYCLES : STAGE_DELAY;
  localparam int unsigned CNT_W   = $clog2(CNT_LIM + 1);
  localparam int unsigned STG_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [STG_W-1:0]        stage_q, stage_d;
  logic [NUM_STAGES-1:0]   rst_q, rst_d;
  logic                    ready_q, ready_d;
  logic [7:0]              lost_q, lost_d;
  logic                    lock_meta_q, lock_s_q;
  logic                    lock_loss_c;

`ifdef UTIL_MW_RST_SEQ_LOCK_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
`endif

  // State register, synchronizer and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= ST_WAIT_LOCK;
      cnt_q       <= '0;
      stage_q     <= '0;
      rst_q       <= '1;
      ready_q     <= 1'b0;
      lost_q      <= 8'd0;
`ifdef UTIL_MW_RST_SEQ_LOCK_TIMEOUT_EN
      wd_q        <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      lock_meta_q <= locked;
      lock_s_q    <= lock_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stage_q     <= stage_d;
      rst_q       <= rst_d;
      ready_q     <= ready_d;
      lost_q      <= lost_d;
`ifdef UTIL_MW_RST_SEQ_LOCK_TIMEOUT_EN
      wd_q        <= wd_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  // Losing lock only counts once resets have started coming out
  assign lock_loss_c = !lock_s_q && ((state_q == ST_RELEASE) || (state_q == ST_RUN));

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    lost_d  = lost_q;
`ifdef UTIL_MW_RST_SEQ_LOCK_TIMEOUT_EN
    wd_d      = '0;
    timeout_d = timeout_q;
`endif

    unique case (state_q)
      ST_WAIT_LOCK: begin
        rst_d   = '1;
        ready_d = 1'b0;
        if (lock_s_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end
      end
      ST_STABLE: begin
        if (!lock_s_q) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          stage_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (lock_s_q) begin
          if (cnt_q == CNT_W'(STAGE_DELAY - 1)) begin
            cnt_d   = '0;
            stage_d = stage_q + STG_W'(1);
            for (int i = 0; i < int'(NUM_STAGES); i++) begin
              if (stage_q == STG_W'(i)) rst_d[i] = 1'b0;
            end
            if (stage_q == STG_W'(NUM_STAGES - 1)) begin
              state_d = ST_RUN;
              ready_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_RUN: begin
      end
      default: state_d = ST_WAIT_LOCK;
    endcase

`ifdef UTIL_MW_RST_SEQ_LOCK_TIMEOUT_EN
    // Watchdog counts only while parked in WAIT_LOCK, then holds at the limit
    if (state_q == ST_WAIT_LOCK) begin
      if (wd_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        wd_d      = wd_q;
        timeout_d = 1'b1;
      end else begin
        wd_d = wd_q + TO_W'(1);
      end
    end
`endif

    // Lock loss takes priority over a simultaneous soft request
    if (lock_loss_c) begin
      state_d = ST_WAIT_LOCK;
      cnt_d   = '0;
      stage_d = '0;
      rst_d   = '1;
      ready_d = 1'b0;
      if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
    end else if (soft_rst_req) begin
      state_d = lock_s_q ? ST_STABLE : ST_WAIT_LOCK;
      cnt_d   = '0;
      stage_d = '0;
      rst_d   = '1;
      ready_d = 1'b0;
`ifdef UTIL_MW_RST_SEQ_LOCK_TIMEOUT_EN
      wd_d      = '0;
      timeout_d = 1'b0;
`endif
    end
  end

  assign rst_out       = rst_q;
  assign ready         = ready_q;
  assign lock_lost_cnt = lost_q;
  assign state_dbg     = state_q;
`ifdef UTIL_MW_RST_SEQ_LOCK_TIMEOUT_EN
  assign lock_timeout  = timeout_q;
`else
  assign lock_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_util_mw_rst_sequencer.sv
// Testbench for util_mw_rst_sequencer. The stimulus process drives inputs on
// the falling edge, advances a sequence-age reference model and queues the
// expected outputs. A monitor pops and compares after every rising edge.
// Directed spot checks against fixed constants are mixed in as well.

module tb_util_mw_rst_sequencer;

  localparam int NS  = 3;
  localparam int LSC = 8;
  localparam int SD  = 4;
  localparam int TO  = 16;
`ifdef UTIL_MW_RST_SEQ_LOCK_TIMEOUT_EN
  localparam int TO_EN = 1;
`else
  localparam int TO_EN = 0;
`endif

  typedef struct packed {
    logic [2:0] rst;
    logic       rdy;
    logic [7:0] lost;
    logic       to;
    logic [2:0] st;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          locked = 1'b0;
  logic          soft_rst_req = 1'b0;
  logic [NS-1:0] rst_out;
  logic          ready;
  logic [7:0]    lock_lost_cnt;
  logic          lock_timeout;
  logic [2:0]    state_dbg;

  int errors = 0;
  int checks = 0;
  exp_t exp_q[$];

  util_mw_rst_sequencer #(
    .NUM_STAGES(NS), .LOCK_STABLE_CYCLES(LSC), .STAGE_DELAY(SD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .locked(locked), .soft_rst_req(soft_rst_req),
    .rst_out(rst_out), .ready(ready), .lock_lost_cnt(lock_lost_cnt),
    .lock_timeout(lock_timeout), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Reference model: sequence age since entering the stability window.
  bit m1 = 1'b0, m2 = 1'b0;
  bit m_in_seq = 1'b0;
  int m_age = 0;
  int m_lost = 0;
  int m_wd = 0;
  bit m_to = 1'b0;

  function automatic int released();
    int r;
    if (!m_in_seq || m_age < LSC) return 0;
    r = (m_age - LSC) / SD;
    return (r > NS) ? NS : r;
  endfunction

  function automatic int phase();
    if (!m_in_seq) return 1;
    if (m_age < LSC) return 2;
    if (released() < NS) return 3;
    return 4;
  endfunction

  task automatic model_edge(input bit r, input bit l, input bit s);
    int ph;
    bit ls;
    if (r) begin
      m1 = 0; m2 = 0; m_in_seq = 0; m_age = 0; m_lost = 0; m_wd = 0; m_to = 0;
      return;
    end
    ph = phase();
    ls = m2;
    if (TO_EN != 0) begin
      if (ph == 1) begin
        if (m_wd == TO - 1) m_to = 1; else m_wd++;
      end else m_wd = 0;
    end
    if (!ls && (ph == 3 || ph == 4)) begin
      m_in_seq = 0;
      if (m_lost < 255) m_lost++;
    end else if (s) begin
      m_in_seq = ls;
      m_age = 0;
      m_wd = 0;
      m_to = 0;
    end else if (ph == 1) begin
      if (ls) begin m_in_seq = 1; m_age = 0; end
    end else if (!ls) begin
      m_in_seq = 0;
    end else if (m_age < 100000) begin
      m_age++;
    end
    m2 = m1;
    m1 = l;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int rel;
    rel = released();
    e.rst  = 3'(((1 << NS) - 1) & ~((1 << rel) - 1));
    e.rdy  = (phase() == 4);
    e.lost = 8'(m_lost);
    e.to   = m_to;
    e.st   = 3'(phase());
    return e;
  endfunction

  task automatic step(input bit r, input bit l, input bit s);
    @(negedge clk);
    reset = r;
    locked = l;
    soft_rst_req = s;
    model_edge(r, l, s);
    exp_q.push_back(model_out());
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: one expected entry per rising edge
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = {rst_out, ready, lock_lost_cnt, lock_timeout, state_dbg};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL scoreboard t=%0t got rst=%b rdy=%b lost=%0d to=%b st=%0d exp rst=%b rdy=%b lost=%0d to=%b st=%0d",
                   $time, a.rst, a.rdy, a.lost, a.to, a.st, e.rst, e.rdy, e.lost, e.to, e.st);
        end
      end
    end
  end

  initial begin
    bit lk;
    step(1, 0, 0);
    step(1, 0, 0);
    settle();
    chk("reset_rst_out", int'(rst_out), 7);
    chk("reset_ready", int'(ready), 0);
    chk("reset_state", int'(state_dbg), 1);
    chk("reset_lost", int'(lock_lost_cnt), 0);

    // Nominal sequence
    for (int i = 0; i < 2; i++) step(0, 1, 0);
    settle();
    chk("nom_wait_edge2", int'(state_dbg), 1);
    step(0, 1, 0);
    settle();
    chk("nom_stable_edge3", int'(state_dbg), 2);
    for (int i = 0; i < 19; i++) step(0, 1, 0);
    settle();
    chk("nom_edge22_rst", int'(rst_out), 3'b100);
    step(0, 1, 0);
    settle();
    chk("nom_edge23_rst", int'(rst_out), 0);
    chk("nom_edge23_ready", int'(ready), 1);
    chk("nom_edge23_state", int'(state_dbg), 4);

    // Lock glitch during STABLE
    step(0, 1, 1);
    settle();
    chk("soft_to_stable", int'(state_dbg), 2);
    chk("soft_rst_ones", int'(rst_out), 7);
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    settle();
    chk("glitch_state", int'(state_dbg), 1);
    chk("glitch_lost", int'(lock_lost_cnt), 0);
    for (int i = 0; i < 22; i++) step(0, 1, 0);
    settle();
    chk("glitch_not_ready", int'(ready), 0);
    step(0, 1, 0);
    settle();
    chk("glitch_ready", int'(ready), 1);

    // Soft request in RUN
    step(0, 1, 1);
    settle();
    chk("softrun_state", int'(state_dbg), 2);
    chk("softrun_rst", int'(rst_out), 7);
    for (int i = 0; i < 19; i++) step(0, 1, 0);
    settle();
    chk("softrun_not_ready", int'(ready), 0);
    step(0, 1, 0);
    settle();
    chk("softrun_ready", int'(ready), 1);

    // Lock loss in RUN
    step(0, 0, 0);
    step(0, 0, 0);
    settle();
    chk("loss_ready_held", int'(ready), 1);
    step(0, 0, 0);
    settle();
    chk("loss_rst", int'(rst_out), 7);
    chk("loss_ready", int'(ready), 0);
    chk("loss_cnt", int'(lock_lost_cnt), 1);
    for (int i = 0; i < 23; i++) step(0, 1, 0);
    settle();
    chk("recover_ready", int'(ready), 1);

    // Soft request and lock loss on the same edge
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    settle();
    chk("both_state", int'(state_dbg), 1);
    chk("both_lost", int'(lock_lost_cnt), 2);

    // Saturation
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 14; i++) step(0, 1, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0);
    end
    settle();
    chk("lost_saturated", int'(lock_lost_cnt), 255);

    // Lock watchdog
    step(1, 0, 0);
    for (int i = 0; i < 15; i++) step(0, 0, 0);
    settle();
    chk("wd_before", int'(lock_timeout), 0);
    step(0, 0, 0);
    settle();
    chk("wd_fire", int'(lock_timeout), TO_EN);
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    settle();
    chk("wd_sticky", int'(lock_timeout), TO_EN);
    step(0, 1, 1);
    settle();
    chk("wd_soft_clear", int'(lock_timeout), 0);

    // Randomized traffic
    lk = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 4) lk = ~lk;
      step(($urandom_range(0, 999) < 3) ? 1'b1 : 1'b0, lk,
           ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0);
    end

    @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
